// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART: data width, the state encoding
// used by both the transmit shifter and the receiver, and the bit-counter width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_CNT_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset (pointers and count only)
//   push  - write din at tail; ignored when full
//   pop   - drop head; ignored when empty
//   din   - write data
//   dout  - head entry, valid whenever empty is low
//   full  - 2**DEPTH_LOG2 entries stored
//   empty - no entries stored
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  wr_en, rd_en;

  assign full  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (rd_en) rptr_d = rptr_q + DEPTH_LOG2'(1);
    if (wr_en && !rd_en)      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    else if (rd_en && !wr_en) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with optional buffered receiver.
// Bytes pushed by the bus side queue in a FIFO and are serialised on tx
// (start 0, 8 data bits LSB first, stop 1), frames sent back to back.
// Optional receiver enabled by defining UART_FIFO_RX_EN.
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-low reset
//   tx_byte       - byte to enqueue
//   transmit      - push strobe, one byte per asserted cycle (dropped when full)
//   tx_fifo_full  - TX FIFO full (registered state)
//   busy          - TX FIFO non-empty or frame in progress
//   tx            - registered serial output, idle high
//   rx            - serial input (UART_FIFO_RX_EN only)
//   rx_fifo_pop   - pop RX FIFO head (UART_FIFO_RX_EN only)
//   rx_fifo_empty - RX FIFO empty (UART_FIFO_RX_EN only)
//   irq           - received data available (UART_FIFO_RX_EN only)
//   rx_byte       - RX FIFO head, show-ahead (UART_FIFO_RX_EN only)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       tx_fifo_full,
  output logic       busy,
  output logic       tx
`ifdef UART_FIFO_RX_EN
  ,
  input  logic       rx,
  input  logic       rx_fifo_pop,
  output logic       rx_fifo_empty,
  output logic       irq,
  output logic [7:0] rx_byte
`endif
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(UART_DATA_BITS - 1);

  logic                 tx_push, tx_pop, tx_empty;
  logic [7:0]           tx_head;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 bit_done;

  // Full is the registered state, so a pop on the same edge never admits a push.
  assign tx_push = transmit && !tx_fifo_full;

  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_byte),
    .dout  (tx_head),
    .full  (tx_fifo_full),
    .empty (tx_empty)
  );

  assign bit_done = (cnt_q == BIT_LAST);
  assign busy     = !tx_empty || (state_q != IDLE);
  assign tx       = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_pop  = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          shreg_d = tx_head;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (bit_done) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == LAST_DATA) state_d = STOP;
          else                    bit_d   = bit_q + BIT_CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next frame: no idle bits between frames.
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            shreg_d = tx_head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one
  // cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

`ifdef UART_FIFO_RX_EN
  localparam logic [CNT_W-1:0] RX_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                 rx_meta_q, rx_sync_q;
  uart_state_e          rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_CNT_W-1:0] rx_bit_q, rx_bit_d;
  logic [7:0]           rx_shreg_q, rx_shreg_d;
  logic                 rx_push, rx_bit_done;

  assign rx_bit_done = (rx_cnt_q == BIT_LAST);
  assign irq         = !rx_fifo_empty;

  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_fifo_pop),
    .din   (rx_shreg_q),
    .dout  (rx_byte),
    .full  (),
    .empty (rx_fifo_empty)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = START;
      end
      START: begin
        // Mid-point re-check: a line already high again was a glitch.
        if (rx_cnt_q == RX_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_bit_done) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
          if (rx_bit_q == LAST_DATA) rx_state_d = STOP;
          else                       rx_bit_d   = rx_bit_q + BIT_CNT_W'(1);
        end
      end
      STOP: begin
        if (rx_bit_done) begin
          rx_cnt_d   = '0;
          rx_state_d = IDLE;
          // Bad stop bit drops the byte; a full FIFO drops it too.
          rx_push    = rx_sync_q;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shreg_q <= rx_shreg_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int L     = 520;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       transmit = 1'b0;
  logic       tx_fifo_full, busy, tx;
`ifdef UART_FIFO_RX_EN
  logic       rx = 1'b1;
  logic       rx_fifo_pop = 1'b0;
  logic       rx_fifo_empty, irq;
  logic [7:0] rx_byte;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int         sched_off[$];
  logic [7:0] sched_val[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_byte      (tx_byte),
    .transmit     (transmit),
    .tx_fifo_full (tx_fifo_full),
    .busy         (busy),
    .tx           (tx)
`ifdef UART_FIFO_RX_EN
    ,
    .rx           (rx),
    .rx_fifo_pop  (rx_fifo_pop),
    .rx_fifo_empty(rx_fifo_empty),
    .irq          (irq),
    .rx_byte      (rx_byte)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each index j is the line state sampled between edge N-1+j and
  // edge N+j, where N is the edge of the first scheduled push (offset 0).
  // The model tracks queued bytes and when the transmitter is free: a byte
  // leaves the queue once the transmitter is free, its frame occupies the line
  // from two edges after that, lasting 10*CPB cycles.
  task automatic run_burst();
    logic       exp_tx   [L];
    logic       exp_busy [L];
    logic       exp_full [L];
    logic       push_at  [L];
    logic [7:0] push_val [L];
    logic [7:0] q[$];
    logic [7:0] b;
    int         free_edge;
    for (int j = 0; j < L; j++) begin
      exp_tx[j] = 1'b1; exp_busy[j] = 1'b0; exp_full[j] = 1'b0;
      push_at[j] = 1'b0; push_val[j] = 8'h00;
    end
    for (int i = 0; i < sched_off.size(); i++) begin
      push_at[sched_off[i]]  = 1'b1;
      push_val[sched_off[i]] = sched_val[i];
    end
    free_edge = 0;
    for (int e = 0; e < L - 1; e++) begin
      int sb;
      sb = q.size();
      if (sb > 0 && e >= free_edge) begin
        b = q.pop_front();
        for (int k = 0; k < FRAME; k++) begin
          int bi;
          logic v;
          bi = k / CPB;
          if (bi == 0)      v = 1'b0;
          else if (bi == 9) v = 1'b1;
          else              v = b[bi-1];
          if (e + 2 + k < L) exp_tx[e+2+k] = v;
        end
        free_edge = e + FRAME;
      end
      if (push_at[e] && sb < DEPTH) q.push_back(push_val[e]);
      exp_busy[e+1] = (q.size() > 0) || (e < free_edge);
      exp_full[e+1] = (q.size() == DEPTH);
    end
    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      check("tx",   32'(tx),           32'(exp_tx[j]));
      check("busy", 32'(busy),         32'(exp_busy[j]));
      check("full", 32'(tx_fifo_full), 32'(exp_full[j]));
      transmit = push_at[j];
      tx_byte  = push_val[j];
    end
    transmit = 1'b0;
    sched_off.delete();
    sched_val.delete();
  endtask

`ifdef UART_FIFO_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic pop_rx();
    rx_fifo_pop = 1'b1;
    @(negedge clk);
    rx_fifo_pop = 1'b0;
  endtask
`endif

  initial begin
    // Reset state and idle line
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx),           32'd1);
    check("rst_busy", 32'(busy),         32'd0);
    check("rst_full", 32'(tx_fifo_full), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx",   32'(tx),           32'd1);
      check("idle_busy", 32'(busy),         32'd0);
      check("idle_full", 32'(tx_fifo_full), 32'd0);
    end

    // Asynchronous reset in the middle of a frame, with bytes still queued
    transmit = 1'b1; tx_byte = 8'h00;
    @(negedge clk);
    tx_byte = 8'h55;
    @(negedge clk);
    tx_byte = 8'h66;
    @(negedge clk);
    transmit = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_tx_low", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_tx",   32'(tx),           32'd1);
    check("arst_busy", 32'(busy),         32'd0);
    check("arst_full", 32'(tx_fifo_full), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_rst_tx",   32'(tx),   32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    // Single byte
    sched_off = '{0};
    sched_val = '{8'hA5};
    run_burst();

    // Three bytes back to back
    sched_off = '{0, 1, 2};
    sched_val = '{8'h01, 8'h02, 8'h03};
    run_burst();

    // Six bytes on consecutive cycles: the last is dropped
    sched_off = '{0, 1, 2, 3, 4, 5};
    sched_val = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    run_burst();

    // Push on the edge where the FIFO is full and the shifter pops
    sched_off = '{0, 1, 2, 3, 4, 1 + FRAME};
    sched_val = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hEE};
    run_burst();

    // Randomised bursts: tight, short gaps and long gaps
    for (int it = 0; it < 12; it++) begin
      int off, n, gmax;
      off  = 0;
      n    = $urandom_range(1, 7);
      gmax = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 3 : 25);
      for (int k = 0; k < n; k++) begin
        sched_off.push_back(off);
        sched_val.push_back(8'($urandom));
        off += 1 + $urandom_range(0, gmax);
      end
      run_burst();
    end

`ifdef UART_FIFO_RX_EN
    check("rx_empty0", 32'(rx_fifo_empty), 32'd1);
    check("irq0",      32'(irq),           32'd0);
    send_rx(8'h3C, 1'b1);
    check("rx_empty", 32'(rx_fifo_empty), 32'd0);
    check("irq",      32'(irq),           32'd1);
    check("rx_byte",  32'(rx_byte),       32'h3C);
    pop_rx();
    check("rx_empty_pop", 32'(rx_fifo_empty), 32'd1);
    check("irq_pop",      32'(irq),           32'd0);
    pop_rx();
    check("rx_pop_empty_ignored", 32'(rx_fifo_empty), 32'd1);
    send_rx(8'h81, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("rx_bad_stop", 32'(rx_fifo_empty), 32'd1);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    check("rx_glitch", 32'(rx_fifo_empty), 32'd1);
    begin
      logic [7:0] rq[$];
      for (int k = 0; k < 3; k++) begin
        logic [7:0] v;
        v = 8'($urandom);
        rq.push_back(v);
        send_rx(v, 1'b1);
      end
      for (int k = 0; k < 3; k++) begin
        check("rx_order_empty", 32'(rx_fifo_empty), 32'd0);
        check("rx_order_byte",  32'(rx_byte),       32'(rq[k]));
        pop_rx();
      end
      check("rx_drained", 32'(rx_fifo_empty), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
